// File: rtl/ahblite_timer_if.sv
// AHB-Lite slave-port bundle for the timer: address/data-phase inputs from the
// bus plus this slave's HREADYOUT/HRESP/HRDATA back to the slave multiplexer.
interface ahblite_timer_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahblite_timer.sv
// AHB-Lite timer slave: 32-bit down counter with reload, sticky flag and a
// registered interrupt. Legal word accesses complete with zero wait states;
// anything else gets the two-cycle ERROR response and leaves registers alone.
module ahblite_timer #(
    parameter int DIV = 1
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahblite_timer_if.slave  bus,
    output logic            TIMER_IRQ
);

    typedef enum logic [1:0] {
        ERR_IDLE,
        ERR_FIRST,
        ERR_SECOND
    } err_state_t;

    localparam logic [15:0] PRESCALE_LAST = 16'(DIV - 1);
    localparam logic [7:0]  ADDR_CTRL     = 8'h00;
    localparam logic [7:0]  ADDR_LOAD     = 8'h04;
    localparam logic [7:0]  ADDR_VALUE    = 8'h08;
    localparam logic [7:0]  ADDR_STATUS   = 8'h0C;

    err_state_t  err_state;
    err_state_t  err_next;

    logic        dp_active;
    logic        dp_illegal;
    logic        dp_write;
    logic [7:0]  dp_addr;

    logic        ctrl_en;
    logic        ctrl_ie;
    logic        ctrl_reload;
    logic [31:0] load_reg;
    logic [31:0] value_reg;
    logic        flag;
    logic [15:0] prescaler;

    logic        accept;
    logic        illegal_ap;
    logic        legal_wr;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic        tick;
    logic        underflow;
    logic        unused_bits;

    assign accept     = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign illegal_ap = (bus.HSIZE != 3'b010) | (bus.HADDR[1:0] != 2'b00)
                      | (bus.HADDR[7:0] > ADDR_STATUS);

    // Only the low address byte and HTRANS[1] matter to this slave.
    assign unused_bits = ^{bus.HADDR[31:8], bus.HTRANS[0]};

    // A write lands on the edge that ends its data phase, i.e. when HREADY is high.
    assign legal_wr  = dp_active & ~dp_illegal & dp_write & bus.HREADY;
    assign wr_ctrl   = legal_wr & (dp_addr == ADDR_CTRL);
    assign wr_load   = legal_wr & (dp_addr == ADDR_LOAD);
    assign wr_status = legal_wr & (dp_addr == ADDR_STATUS);

    assign tick      = ctrl_en & (prescaler == PRESCALE_LAST);
    assign underflow = tick & (value_reg == 32'd0);

    // Capture the address phase; a low HREADY stalls the pipeline so everything holds.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_active  <= 1'b0;
            dp_illegal <= 1'b0;
            dp_write   <= 1'b0;
            dp_addr    <= 8'h00;
        end else if (bus.HREADY) begin
            dp_active  <= accept;
            dp_illegal <= illegal_ap;
            dp_write   <= bus.HWRITE;
            dp_addr    <= bus.HADDR[7:0];
        end
    end

    // Error response state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_state <= ERR_IDLE;
        end else begin
            err_state <= err_next;
        end
    end

    // Two-cycle ERROR sequence; ERR_SECOND can chain straight into another error.
    always_comb begin
        err_next      = err_state;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        case (err_state)
            ERR_IDLE: begin
                if (accept & illegal_ap) begin
                    err_next = ERR_FIRST;
                end
            end
            ERR_FIRST: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
                err_next      = ERR_SECOND;
            end
            ERR_SECOND: begin
                bus.HRESP = 1'b1;
                if (accept & illegal_ap) begin
                    err_next = ERR_FIRST;
                end else begin
                    err_next = ERR_IDLE;
                end
            end
            default: begin
                err_next = ERR_IDLE;
            end
        endcase
    end

    // Read mux is combinational in the data phase and parks at zero otherwise.
    always_comb begin
        bus.HRDATA = 32'd0;
        if (dp_active & ~dp_illegal & ~dp_write) begin
            case (dp_addr)
                ADDR_CTRL:   bus.HRDATA = {29'd0, ctrl_reload, ctrl_ie, ctrl_en};
                ADDR_LOAD:   bus.HRDATA = load_reg;
                ADDR_VALUE:  bus.HRDATA = value_reg;
                ADDR_STATUS: bus.HRDATA = {31'd0, flag};
                default:     bus.HRDATA = 32'd0;
            endcase
        end
    end

    // Prescaler runs 0..DIV-1 while enabled and sits at zero while disabled.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            prescaler <= 16'd0;
        end else if (!ctrl_en || tick) begin
            prescaler <= 16'd0;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    // CTRL: a bus write wins over the one-shot auto-disable on underflow.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_en     <= 1'b0;
            ctrl_ie     <= 1'b0;
            ctrl_reload <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en     <= bus.HWDATA[0];
            ctrl_ie     <= bus.HWDATA[1];
            ctrl_reload <= bus.HWDATA[2];
        end else if (underflow && !ctrl_reload) begin
            ctrl_en <= 1'b0;
        end
    end

    // LOAD only changes from the bus.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            load_reg <= 32'd0;
        end else if (wr_load) begin
            load_reg <= bus.HWDATA;
        end
    end

    // VALUE: a LOAD write overrides whatever the tick would have done.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            value_reg <= 32'd0;
        end else if (wr_load) begin
            value_reg <= bus.HWDATA;
        end else if (tick) begin
            if (value_reg != 32'd0) begin
                value_reg <= value_reg - 32'd1;
            end else if (ctrl_reload) begin
                value_reg <= load_reg;
            end
        end
    end

    // FLAG: setting on underflow wins over a simultaneous write-1-to-clear.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            flag <= 1'b0;
        end else if (underflow) begin
            flag <= 1'b1;
        end else if (wr_status && bus.HWDATA[0]) begin
            flag <= 1'b0;
        end
    end

    // Interrupt is a registered copy of the gated flag, one cycle behind it.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            TIMER_IRQ <= 1'b0;
        end else begin
            TIMER_IRQ <= flag & ctrl_ie;
        end
    end

endmodule

// File: tb/tb_ahblite_timer.sv
// Bench for ahblite_timer: two instances (DIV=1 and DIV=4) share one bus
// stimulus and are compared every cycle against a behavioural model of the
// register file, then a long randomized run is checked the same way.
module tb_ahblite_timer;

    logic        HCLK = 1'b0;
    logic        resetReq;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic        readyRoll;
    logic        irq1;
    logic        irq4;

    int checkCount = 0;
    int failCount  = 0;

    // Behavioural model state, index 0 = DIV 1 instance, index 1 = DIV 4 instance.
    int          divOf [2] = '{1, 4};
    logic        mEn    [2];
    logic        mIe    [2];
    logic        mRel   [2];
    logic        mFlag  [2];
    logic        mIrq   [2];
    int          mPre   [2];
    logic [31:0] mLoad  [2];
    logic [31:0] mValue [2];
    logic        dpActive;
    logic        dpWrite;
    logic        dpIllegal;
    logic [7:0]  dpAddr;
    int          errLeft;
    logic [31:0] lastRd [2];

    ahblite_timer_if bus1 ();
    ahblite_timer_if bus4 ();

    assign bus1.HSEL   = hsel;
    assign bus1.HADDR  = haddr;
    assign bus1.HTRANS = htrans;
    assign bus1.HSIZE  = hsize;
    assign bus1.HWRITE = hwrite;
    assign bus1.HWDATA = hwdata;
    assign bus1.HREADY = hready;
    assign bus4.HSEL   = hsel;
    assign bus4.HADDR  = haddr;
    assign bus4.HTRANS = htrans;
    assign bus4.HSIZE  = hsize;
    assign bus4.HWRITE = hwrite;
    assign bus4.HWDATA = hwdata;
    assign bus4.HREADY = hready;

    ahblite_timer #(.DIV(1)) dut1 (
        .HCLK      (HCLK),
        .HRESET    (resetReq),
        .bus       (bus1),
        .TIMER_IRQ (irq1)
    );

    ahblite_timer #(.DIV(4)) dut4 (
        .HCLK      (HCLK),
        .HRESET    (resetReq),
        .bus       (bus4),
        .TIMER_IRQ (irq4)
    );

    // Free-running bus clock.
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expRead(input int k);
        logic [31:0] r;
        r = 32'd0;
        if (dpActive && !dpIllegal && !dpWrite) begin
            if (dpAddr == 8'h00) r = {29'd0, mRel[k], mIe[k], mEn[k]};
            else if (dpAddr == 8'h04) r = mLoad[k];
            else if (dpAddr == 8'h08) r = mValue[k];
            else if (dpAddr == 8'h0C) r = {31'd0, mFlag[k]};
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs present before it.
    task automatic modelEdge();
        logic acc;
        logic ill;
        logic wrLegal;
        logic tick;
        logic under;
        if (resetReq) begin
            for (int k = 0; k < 2; k++) begin
                mEn[k] = 0; mIe[k] = 0; mRel[k] = 0; mFlag[k] = 0; mIrq[k] = 0;
                mPre[k] = 0; mLoad[k] = 0; mValue[k] = 0;
            end
            dpActive = 0; dpWrite = 0; dpIllegal = 0; dpAddr = 0; errLeft = 0;
            return;
        end
        acc     = hsel && hready && htrans[1];
        ill     = (hsize != 3'd2) || (haddr[1:0] != 2'd0) || (haddr[7:0] > 8'h0C);
        wrLegal = dpActive && !dpIllegal && dpWrite && hready;
        for (int k = 0; k < 2; k++) begin
            logic        nEn, nIe, nRel, nFlag;
            logic [31:0] nLoad, nValue;
            int          nPre;
            nEn = mEn[k]; nIe = mIe[k]; nRel = mRel[k]; nFlag = mFlag[k];
            nLoad = mLoad[k]; nValue = mValue[k];
            tick  = mEn[k] && (mPre[k] == divOf[k] - 1);
            under = tick && (mValue[k] == 0);
            nPre  = (!mEn[k] || tick) ? 0 : mPre[k] + 1;
            if (tick) begin
                if (mValue[k] != 0) begin
                    nValue = mValue[k] - 1;
                end else begin
                    nFlag = 1;
                    if (mRel[k]) nValue = mLoad[k];
                    else nEn = 0;
                end
            end
            if (wrLegal) begin
                if (dpAddr == 8'h00) begin
                    nEn = hwdata[0]; nIe = hwdata[1]; nRel = hwdata[2];
                end else if (dpAddr == 8'h04) begin
                    nLoad = hwdata; nValue = hwdata;
                end else if (dpAddr == 8'h0C && hwdata[0] && !under) begin
                    nFlag = 0;
                end
            end
            mIrq[k] = mFlag[k] && mIe[k];
            mEn[k] = nEn; mIe[k] = nIe; mRel[k] = nRel; mFlag[k] = nFlag;
            mLoad[k] = nLoad; mValue[k] = nValue; mPre[k] = nPre;
        end
        if (errLeft == 2) errLeft = 1;
        else if (acc && ill) errLeft = 2;
        else errLeft = 0;
        if (hready) begin
            dpActive = acc; dpWrite = hwrite; dpIllegal = ill; dpAddr = haddr[7:0];
        end
    endtask

    // One bus cycle: settle HREADY, compare outputs mid-cycle, then clock the model.
    task automatic cycle();
        hready = (errLeft == 2) ? 1'b0 : readyRoll;
        @(negedge HCLK);
        checkOutput("d1_hreadyout", 32'(bus1.HREADYOUT), 32'(errLeft != 2));
        checkOutput("d1_hresp", 32'(bus1.HRESP), 32'(errLeft != 0));
        checkOutput("d1_hrdata", bus1.HRDATA, expRead(0));
        checkOutput("d1_irq", 32'(irq1), 32'(mIrq[0]));
        checkOutput("d4_hreadyout", 32'(bus4.HREADYOUT), 32'(errLeft != 2));
        checkOutput("d4_hresp", 32'(bus4.HRESP), 32'(errLeft != 0));
        checkOutput("d4_hrdata", bus4.HRDATA, expRead(1));
        checkOutput("d4_irq", 32'(irq4), 32'(mIrq[1]));
        lastRd[0] = bus1.HRDATA;
        lastRd[1] = bus4.HRDATA;
        @(posedge HCLK);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                                 input logic [2:0] size, input logic write, input logic [31:0] data);
        hsel = sel; haddr = addr; htrans = trans; hsize = size; hwrite = write; hwdata = data;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'b00, 3'd2, 0, 0);
    endtask

    task automatic busWrite(input logic [7:0] addr, input logic [31:0] data, input logic [2:0] size);
        applyStimulus(1, {24'hA5A5A5, addr}, 2'b10, size, 1, 0);
        applyStimulus(0, 0, 2'b00, 3'd2, 0, data);
    endtask

    task automatic busRead(input logic [7:0] addr);
        applyStimulus(1, {24'h000000, addr}, 2'b10, 3'd2, 0, 0);
        applyStimulus(0, 0, 2'b00, 3'd2, 0, 0);
    endtask

    initial begin
        logic [31:0] r;
        resetReq = 1; readyRoll = 1; hready = 1;
        hsel = 0; haddr = 0; htrans = 0; hsize = 3'd2; hwrite = 0; hwdata = 0;
        for (int k = 0; k < 2; k++) lastRd[k] = 0;
        repeat (2) @(posedge HCLK);
        modelEdge();
        #1;
        idle(2);
        resetReq = 0;

        // Reset values visible through every register.
        for (int a = 0; a < 16; a += 4) begin
            busRead(8'(a));
            checkOutput("rst_read_d1", lastRd[0], 32'd0);
            checkOutput("rst_read_d4", lastRd[1], 32'd0);
        end

        // Auto-reload countdown with interrupt enabled.
        busWrite(8'h04, 32'd3, 3'd2);
        busWrite(8'h00, 32'h7, 3'd2);
        for (int i = 0; i < 6; i++) busRead(8'h08);
        idle(6);

        // Flag set by a tick beats a simultaneous clear, then a quiet clear works.
        busWrite(8'h04, 32'd0, 3'd2);
        busWrite(8'h0C, 32'h1, 3'd2);
        idle(2);
        busWrite(8'h00, 32'h2, 3'd2);
        busWrite(8'h0C, 32'h1, 3'd2);
        idle(2);
        checkOutput("clear_irq_d1", 32'(irq1), 32'd0);
        busRead(8'h0C);
        checkOutput("clear_flag_d1", lastRd[0], 32'd0);

        // One-shot mode disables itself after the underflow.
        busWrite(8'h04, 32'd2, 3'd2);
        busWrite(8'h00, 32'h1, 3'd2);
        idle(30);
        busRead(8'h00);
        checkOutput("oneshot_ctrl_d1", lastRd[0], 32'd0);
        checkOutput("oneshot_ctrl_d4", lastRd[1], 32'd0);
        busRead(8'h0C);
        checkOutput("oneshot_flag_d1", lastRd[0], 32'd1);
        checkOutput("oneshot_flag_d4", lastRd[1], 32'd1);

        // Illegal accesses, including back-to-back ones, leave LOAD alone.
        busWrite(8'h04, 32'h1234, 3'd2);
        busRead(8'h10);
        idle(1);
        busWrite(8'h04, 32'hFFFF, 3'd0);
        idle(1);
        applyStimulus(1, 32'h10, 2'b10, 3'd2, 0, 0);
        applyStimulus(1, 32'h10, 2'b10, 3'd2, 0, 0);
        applyStimulus(1, 32'h06, 2'b11, 3'd2, 1, 0);
        idle(3);
        busRead(8'h04);
        checkOutput("illegal_load_d1", lastRd[0], 32'h1234);
        checkOutput("illegal_load_d4", lastRd[1], 32'h1234);

        // Periodic ticks, then a reset that lands on a pending write data phase.
        busWrite(8'h04, 32'd1, 3'd2);
        busWrite(8'h00, 32'h5, 3'd2);
        for (int i = 0; i < 8; i++) busRead(8'h08);
        applyStimulus(1, 32'h04, 2'b10, 3'd2, 1, 0);
        resetReq = 1;
        applyStimulus(0, 0, 2'b00, 3'd2, 0, 32'hDEAD_BEEF);
        resetReq = 0;
        for (int a = 0; a < 16; a += 4) begin
            busRead(8'(a));
            checkOutput("rst_write_d1", lastRd[0], 32'd0);
            checkOutput("rst_write_d4", lastRd[1], 32'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            resetReq  = ($urandom_range(0, 299) == 0);
            readyRoll = ($urandom_range(0, 7) != 0);
            hsel      = ($urandom_range(0, 7) != 0);
            htrans    = ($urandom_range(0, 5) < 2) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            hsize     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            hwrite    = 1'($urandom_range(0, 1));
            haddr     = $urandom;
            if ($urandom_range(0, 5) == 0) haddr[7:0] = 8'($urandom_range(0, 255));
            else haddr[7:0] = {4'd0, 2'($urandom_range(0, 3)), 2'b00};
            r = $urandom;
            if (dpAddr == 8'h04) begin
                hwdata = 32'($urandom_range(0, 6));
            end else begin
                hwdata = r;
                if (dpAddr == 8'h00 && r[9:8] != 2'b00) hwdata[0] = 1'b1;
            end
            cycle();
        end
        resetReq = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
